// File: rtl/mac_mem_seq.sv
// mac_mem_seq: OBI-style memory sequencer feeding loads to and writing results from the MAC unit.
// Optional MAC_MEM_SEQ_ERR_EN adds data_err_i/err_o and aborts a sequence on an error response.
module mac_mem_seq #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LOAD_WORDS   = 2,
  parameter int WB_WORDS_ACC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  accum_mode_i,
  output logic                  cmd_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
`ifdef MAC_MEM_SEQ_ERR_EN
  input  logic                  data_err_i,
  output logic                  err_o,
`endif
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  output logic [31:0]           mem_rdata_o,
  output logic [31:0]           weight_data_cnt_o,
  output logic [31:0]           active_data_cnt_o,
  output logic [31:0]           wb_data_cnt_o,
  input  logic [31:0]           mem_wdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t                state;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] base;
  logic                  accum;
  logic [31:0]           idx;
  logic [31:0]           total;
  logic                  rsp_err;
`ifdef MAC_MEM_SEQ_ERR_EN
  assign rsp_err = data_err_i;
`else
  assign rsp_err = 1'b0;
`endif
  always_comb total = (op == 2'b11) ? (accum ? 32'(WB_WORDS_ACC) : 32'd1) : 32'(LOAD_WORDS);
  assign cmd_ready_o  = state == IDLE;
  assign busy_o       = state == REQ || state == WAIT;
  assign done_o       = state == DONE;
  assign data_req_o   = state == REQ;
  assign data_we_o    = data_req_o && op == 2'b11;
  assign data_be_o    = data_req_o ? 4'hF : 4'h0;
  assign data_addr_o  = data_req_o ? base + ADDR_WIDTH'({idx, 2'b00}) : '0;
  assign data_wdata_o = data_we_o ? mem_wdata_i : 32'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      op                <= 2'b00;
      base              <= '0;
      accum             <= 1'b0;
      idx               <= 32'd0;
      mem_rdata_o       <= 32'd0;
      weight_data_cnt_o <= 32'd0;
      active_data_cnt_o <= 32'd0;
      wb_data_cnt_o     <= 32'd0;
`ifdef MAC_MEM_SEQ_ERR_EN
      err_o             <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid_i && cmd_op_i != 2'b00) begin
          state <= REQ;
          op    <= cmd_op_i;
          base  <= cmd_addr_i;
          accum <= accum_mode_i;
          idx   <= 32'd0;
          if (cmd_op_i == 2'b01) weight_data_cnt_o <= 32'd0;
          if (cmd_op_i == 2'b10) active_data_cnt_o <= 32'd0;
          if (cmd_op_i == 2'b11) wb_data_cnt_o <= 32'd0;
`ifdef MAC_MEM_SEQ_ERR_EN
          err_o <= 1'b0;
`endif
        end
        REQ: if (data_gnt_i) state <= WAIT;
        WAIT: if (data_rvalid_i) begin
          if (rsp_err) begin
            state <= DONE;
`ifdef MAC_MEM_SEQ_ERR_EN
            err_o <= 1'b1;
`endif
          end else begin
            state <= (idx + 32'd1 < total) ? REQ : DONE;
            idx   <= idx + 32'd1;
            if (op != 2'b11) mem_rdata_o <= data_rdata_i;
            if (op == 2'b01) weight_data_cnt_o <= weight_data_cnt_o + 32'd1;
            if (op == 2'b10) active_data_cnt_o <= active_data_cnt_o + 32'd1;
            if (op == 2'b11) wb_data_cnt_o <= wb_data_cnt_o + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_mem_seq.sv
// tb_mac_mem_seq: directed self-checking bench for mac_mem_seq using immediate assertions.
module tb_mac_mem_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = 32'd0;
  logic        accum = 1'b0;
  logic        cmd_ready, busy, done, data_req, data_we;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] addr, wdata, mem_rdata, wcnt, acnt, wbcnt, mem_wdata;
  logic [3:0]  be;
`ifdef MAC_MEM_SEQ_ERR_EN
  logic        derr = 1'b0;
  logic        err;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always_comb mem_wdata = 32'hA0 + wbcnt;
  mac_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
    .accum_mode_i(accum), .cmd_ready_o(cmd_ready), .busy_o(busy), .done_o(done),
    .data_req_o(data_req), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
`ifdef MAC_MEM_SEQ_ERR_EN
    .data_err_i(derr), .err_o(err),
`endif
    .data_addr_o(addr), .data_we_o(data_we), .data_be_o(be), .data_wdata_o(wdata),
    .mem_rdata_o(mem_rdata), .weight_data_cnt_o(wcnt), .active_data_cnt_o(acnt),
    .wb_data_cnt_o(wbcnt), .mem_wdata_i(mem_wdata)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; accum = acc;
    step();
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask
  // Called while the DUT sits in REQ; holds off the grant for gdly cycles, then answers.
  task automatic xfer(input string tag, input logic [31:0] ea, input logic ewe,
                      input logic [31:0] ewd, input int gdly, input logic [31:0] rd);
    for (int i = 0; i < gdly; i++) begin
      chk({tag, " held req"}, 32'(data_req), 32'd1);
      chk({tag, " held addr"}, addr, ea);
      step();
    end
    chk({tag, " req"}, 32'(data_req), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " addr"}, addr, ea);
    chk({tag, " we"}, 32'(data_we), 32'(ewe));
    chk({tag, " be"}, 32'(be), 32'hF);
    if (ewe) chk({tag, " wdata"}, wdata, ewd);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk({tag, " wait req"}, 32'(data_req), 32'd0);
    rvalid = 1'b1; rdata = rd;
    step();
    rvalid = 1'b0;
  endtask
  initial begin
    step();
    chk("rst ready", 32'(cmd_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req", 32'(data_req), 32'd0);
    chk("rst addr", addr, 32'd0);
    chk("rst rdata", mem_rdata, 32'd0);
    rst_n = 1'b1;
    issue(2'b00, 32'h1000, 1'b0);
    chk("op00 ready", 32'(cmd_ready), 32'd1);
    chk("op00 busy", 32'(busy), 32'd0);
    // weight load, immediate grant
    issue(2'b01, 32'h1000, 1'b0);
    chk("wl cnt0", wcnt, 32'd0);
    xfer("wl w0", 32'h1000, 1'b0, 32'd0, 0, 32'h11112222);
    chk("wl rdata0", mem_rdata, 32'h11112222);
    chk("wl cnt1", wcnt, 32'd1);
    xfer("wl w1", 32'h1004, 1'b0, 32'd0, 0, 32'h33334444);
    chk("wl done", 32'(done), 32'd1);
    chk("wl rdata1", mem_rdata, 32'h33334444);
    chk("wl cnt2", wcnt, 32'd2);
    step();
    chk("wl done off", 32'(done), 32'd0);
    chk("wl idle", 32'(cmd_ready), 32'd1);
    // activation load, grant delayed 3 cycles
    issue(2'b10, 32'h3000, 1'b0);
    xfer("al w0", 32'h3000, 1'b0, 32'd0, 3, 32'hCAFE0001);
    xfer("al w1", 32'h3004, 1'b0, 32'd0, 3, 32'hCAFE0002);
    chk("al done", 32'(done), 32'd1);
    chk("al acnt", acnt, 32'd2);
    chk("al wcnt hold", wcnt, 32'd2);
    chk("al rdata", mem_rdata, 32'hCAFE0002);
    step();
    // writeback, accumulate mode
    issue(2'b11, 32'h2000, 1'b1);
    xfer("wb0", 32'h2000, 1'b1, 32'hA0, 0, 32'd0);
    xfer("wb1", 32'h2004, 1'b1, 32'hA1, 1, 32'd0);
    xfer("wb2", 32'h2008, 1'b1, 32'hA2, 0, 32'd0);
    xfer("wb3", 32'h200C, 1'b1, 32'hA3, 0, 32'd0);
    chk("wb done", 32'(done), 32'd1);
    chk("wb cnt", wbcnt, 32'd4);
    chk("wb rdata hold", mem_rdata, 32'hCAFE0002);
    step();
    // writeback, single word
    issue(2'b11, 32'h2400, 1'b0);
    xfer("wbs", 32'h2400, 1'b1, 32'hA0, 0, 32'd0);
    chk("wbs done", 32'(done), 32'd1);
    chk("wbs cnt", wbcnt, 32'd1);
    step();
    chk("wbs idle", 32'(cmd_ready), 32'd1);
    // reset while waiting on a load response
    issue(2'b01, 32'h1000, 1'b0);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr ready", 32'(cmd_ready), 32'd1);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr done", 32'(done), 32'd0);
    chk("mr req", 32'(data_req), 32'd0);
    chk("mr rdata", mem_rdata, 32'd0);
    chk("mr wcnt", wcnt, 32'd0);
    chk("mr acnt", acnt, 32'd0);
    chk("mr wbcnt", wbcnt, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    step();
    rvalid = 1'b0;
    chk("mr late rdata", mem_rdata, 32'd0);
    chk("mr late wcnt", wcnt, 32'd0);
    chk("mr late ready", 32'(cmd_ready), 32'd1);
`ifdef MAC_MEM_SEQ_ERR_EN
    issue(2'b01, 32'h1000, 1'b0);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rvalid = 1'b1; derr = 1'b1; rdata = 32'h55555555;
    step();
    rvalid = 1'b0; derr = 1'b0;
    chk("er done", 32'(done), 32'd1);
    chk("er err", 32'(err), 32'd1);
    chk("er cnt", wcnt, 32'd0);
    chk("er rdata", mem_rdata, 32'd0);
    step();
    chk("er sticky", 32'(err), 32'd1);
    issue(2'b10, 32'h3000, 1'b0);
    chk("er clear", 32'(err), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
